// File: rtl/fetch_sequencer_pkg.sv
// Shared types and default constants for the accumulator-core fetch sequencer.
`default_nettype none

package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  localparam int PC_W_DEF     = 10;
  localparam int LOAD_LAT_DEF = 1;
  localparam int SCNT_W       = 2;  // holds LOAD_LAT-1 for LOAD_LAT up to 3

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// PC owner for the 9-bit accumulator core: Start/Ack run handshake,
// load stalls and absolute branch redirects, plus a saturating run-cycle counter.
`default_nettype none

module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              LOAD_LAT   = LOAD_LAT_DEF,
  parameter int              CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Branch_i,
  input  logic             Zero_i,
  input  logic             Mem_read_i,
  input  logic             Done_i,
  input  logic [PC_W-1:0]  Target_i,
  output logic [PC_W-1:0]  PC,
  output logic             Commit,
  output logic             Stall,
  output logic             Ack,
  output logic [CNT_W-1:0] Cycle_cnt
);

  seq_state_t        state, state_nxt;
  logic [PC_W-1:0]   pc_q, pc_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [SCNT_W-1:0] scnt_q, scnt_nxt;
  logic              ack_q;
  logic              commit_c, stall_c;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      pc_q   <= START_ADDR;
      cnt_q  <= '0;
      scnt_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc_q   <= pc_nxt;
      cnt_q  <= cnt_nxt;
      scnt_q <= scnt_nxt;
      ack_q  <= (state_nxt == HALT);
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    cnt_nxt   = cnt_q;
    scnt_nxt  = scnt_q;
    commit_c  = 1'b0;
    stall_c   = 1'b0;

    // The counter covers every RUN/STALL cycle and sticks at all-ones.
    if ((state == RUN || state == STALL) && !(&cnt_q)) begin
      cnt_nxt = cnt_q + 1'b1;
    end

    unique case (state)
      IDLE, HALT: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = START_ADDR;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (Done_i) begin
          state_nxt = HALT;
        end else if (Mem_read_i) begin
          state_nxt = STALL;
          stall_c   = 1'b1;
          scnt_nxt  = SCNT_W'(LOAD_LAT - 1);
        end else begin
          commit_c = 1'b1;
          pc_nxt   = (Branch_i && Zero_i) ? Target_i : pc_q + 1'b1;
        end
      end
      STALL: begin
        stall_c = 1'b1;
        if (scnt_q == '0) begin
          commit_c  = 1'b1;
          pc_nxt    = pc_q + 1'b1;
          state_nxt = RUN;
        end else begin
          scnt_nxt = scnt_q - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Same-cycle strobes are suppressed while reset is held.
  assign Commit    = commit_c & ~Reset;
  assign Stall     = stall_c & ~Reset;
  assign PC        = pc_q;
  assign Ack       = ack_q;
  assign Cycle_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: directed program walk, then random decoder traffic.
`default_nettype none

module tb_fetch_sequencer;

  localparam int PC_W     = 10;
  localparam int LOAD_LAT = 3;
  localparam int CNT_W    = 8;
  localparam int PC_MOD   = 1 << PC_W;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic             Branch_i = 1'b0;
  logic             Zero_i = 1'b0;
  logic             Mem_read_i = 1'b0;
  logic             Done_i = 1'b0;
  logic [PC_W-1:0]  Target_i = '0;
  logic [PC_W-1:0]  PC;
  logic             Commit;
  logic             Stall;
  logic             Ack;
  logic [CNT_W-1:0] Cycle_cnt;

  fetch_sequencer #(
    .PC_W      (PC_W),
    .START_ADDR('0),
    .LOAD_LAT  (LOAD_LAT),
    .CNT_W     (CNT_W)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Branch_i  (Branch_i),
    .Zero_i    (Zero_i),
    .Mem_read_i(Mem_read_i),
    .Done_i    (Done_i),
    .Target_i  (Target_i),
    .PC        (PC),
    .Commit    (Commit),
    .Stall     (Stall),
    .Ack       (Ack),
    .Cycle_cnt (Cycle_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic             ack;
    logic [CNT_W-1:0] cnt;
    logic             commit;
    logic             stall;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: the program is "running" or not, a load occupies a number of
  // remaining stall cycles, and everything else is one instruction per clock.
  bit running, halted;
  int m_pc, m_cnt, load_left;

  task automatic model_reset();
    running = 0; halted = 0; m_pc = 0; m_cnt = 0; load_left = 0;
  endtask

  task automatic cycle(input bit rst, input bit st, input bit br, input bit z,
                       input bit mr, input bit dn, input int tgt);
    exp_t e;
    Reset = rst; Start = st; Branch_i = br; Zero_i = z;
    Mem_read_i = mr; Done_i = dn; Target_i = PC_W'(tgt);
    e.pc = PC_W'(m_pc); e.ack = halted; e.cnt = CNT_W'(m_cnt);
    e.commit = 1'b0; e.stall = 1'b0;
    if (rst) begin
      model_reset();
    end else if (!running) begin
      if (st) begin running = 1; halted = 0; m_pc = 0; m_cnt = 0; end
    end else begin
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      if (load_left > 0) begin
        e.stall = 1'b1;
        load_left--;
        if (load_left == 0) begin e.commit = 1'b1; m_pc = (m_pc + 1) % PC_MOD; end
      end else if (dn) begin
        running = 0; halted = 1;
      end else if (mr) begin
        e.stall = 1'b1;
        load_left = LOAD_LAT;
      end else begin
        e.commit = 1'b1;
        m_pc = (br && z) ? tgt : (m_pc + 1) % PC_MOD;
      end
    end
    exp_q.push_back(e);
    @(posedge Clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc",        ($isunknown(PC)        ? -1 : int'(PC)),        int'(e.pc));
      chk("ack",       ($isunknown(Ack)       ? -1 : int'(Ack)),       int'(e.ack));
      chk("cycle_cnt", ($isunknown(Cycle_cnt) ? -1 : int'(Cycle_cnt)), int'(e.cnt));
      chk("commit",    ($isunknown(Commit)    ? -1 : int'(Commit)),    int'(e.commit));
      chk("stall",     ($isunknown(Stall)     ? -1 : int'(Stall)),     int'(e.stall));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle_cycles(2);
    cycle(0, 1, 0, 0, 0, 0, 0);          // accept Start
    idle_cycles(3);                      // PC 0,1,2
    cycle(0, 0, 0, 0, 1, 0, 0);          // load at PC 3
    idle_cycles(LOAD_LAT);
    idle_cycles(3);                      // PC 4,5,6
    cycle(0, 0, 1, 1, 0, 0, 'h020);      // taken branch at 7
    cycle(0, 0, 1, 0, 0, 0, 'h100);      // not taken at 0x20
    cycle(0, 1, 0, 0, 0, 0, 0);          // Start mid-run ignored
    cycle(0, 1, 1, 1, 0, 0, 'h3FE);
    idle_cycles(3);                      // 0x3FE, 0x3FF, wrap to 0
    cycle(0, 0, 0, 0, 0, 1, 0);          // done
    idle_cycles(3);                      // HALT holds, Ack high
    cycle(0, 1, 0, 0, 0, 0, 0);          // restart
    idle_cycles(2);
    cycle(0, 0, 0, 0, 1, 0, 0);          // load, then reset on second stall cycle
    idle_cycles(1);
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle_cycles(2);
    cycle(0, 1, 0, 0, 0, 0, 0);
    idle_cycles(CNT_MAX + 20);           // counter saturates
    cycle(0, 0, 0, 0, 0, 1, 0);
    idle_cycles(2);

    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 39) == 0),
            int'($urandom_range(0, PC_MOD - 1)));
    end
    idle_cycles(1);

    @(negedge Clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
